// File: rtl/vga_sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_pkg
//   Shared VGA timing constants (640x480 @ 60 Hz defaults), the derived
//   window margins, and the per-axis phase encoding. The colour-assignment
//   stage uses the same margins.
//
//   Configuration macro: VGA_SYNC_POSITIVE_EN
//     defined   -> Hsync/Vsync active-high (idle level 0)
//     undefined -> Hsync/Vsync active-low  (idle level 1)
// -----------------------------------------------------------------------------
package vga_sync_gen_pkg;

  localparam int VGA_REZ_MAX_WIDTH = 11;

  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;

  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;

  localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_H_LEFT  = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_H_RIGHT = VGA_H_LEFT + VGA_H_ACTIVE;  // exclusive
  localparam int VGA_V_LEFT  = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_RIGHT = VGA_V_LEFT + VGA_V_ACTIVE;  // exclusive

  // Phase of one axis. Position 0 is the first sync pixel/line.
  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_e;

`ifdef VGA_SYNC_POSITIVE_EN
  localparam logic SYNC_ACTIVE_LVL = 1'b1;
`else
  localparam logic SYNC_ACTIVE_LVL = 1'b0;
`endif

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One timing axis: a wrapping position counter plus the
//   SYNC -> BACK -> ACTIVE -> FRONT -> SYNC phase FSM. Used once for the
//   horizontal axis (stepped every pixel tick) and once for the vertical
//   axis (stepped on line wrap).
//
//   Ports:
//     clk_i      clock
//     rst_i      synchronous active-high reset (count = TOTAL-1, phase FRONT)
//     step_i     advance one position on this edge
//     count_o    registered position
//     count_d_o  position after this edge (next-state)
//     phase_o    registered phase (also the FSM debug view)
//     phase_d_o  phase after this edge (next-state)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int WIDTH    = 11,
  parameter int SYNC_LEN = 96,
  parameter int LEFT     = 144,
  parameter int RIGHT    = 784,
  parameter int TOTAL    = 800
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_d_o,
  output logic [1:0]       phase_o,
  output logic [1:0]       phase_d_o
);

  localparam logic [WIDTH-1:0] LAST_C  = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] SYNC_C  = WIDTH'(SYNC_LEN);
  localparam logic [WIDTH-1:0] LEFT_C  = WIDTH'(LEFT);
  localparam logic [WIDTH-1:0] RIGHT_C = WIDTH'(RIGHT);

  logic [WIDTH-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = (count_q == LAST_C) ? '0 : count_q + WIDTH'(1);
    end
  end

  // Phase changes on the step that enters each threshold count.
  always_comb begin
    phase_d = phase_q;
    if (step_i) begin
      if (count_d == '0)          phase_d = PH_SYNC;
      else if (count_d == SYNC_C) phase_d = PH_BACK;
      else if (count_d == LEFT_C) phase_d = PH_ACTIVE;
      else if (count_d == RIGHT_C) phase_d = PH_FRONT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= LAST_C;
      phase_q <= PH_FRONT;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign phase_o   = phase_q;
  assign phase_d_o = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   VGA timing generator: position counters, sync pulses, visible-window
//   flag and a one-pixel-ahead data request. Everything advances only on
//   Clk edges where the pixel tick En is high. All outputs are registered
//   from the next count value, so they line up with Count_h/Count_v.
//
//   Configuration macro: VGA_SYNC_POSITIVE_EN (see vga_sync_gen_pkg) selects
//   sync polarity; all other outputs are identical in both builds.
//
//   Ports:
//     Clk          system clock
//     Rst          synchronous active-high reset, overrides En
//     En           pixel tick
//     Count_h      horizontal position 0..H_TOTAL-1
//     Count_v      vertical position 0..V_TOTAL-1
//     Hsync/Vsync  sync outputs
//     Active       current position is visible
//     Data_req     position reached by the next En is visible
//     Line_start   one-Clk pulse as Count_h becomes 0
//     Frame_start  one-Clk pulse as (Count_h,Count_v) becomes (0,0)
//     Phase_h_dbg  horizontal phase FSM state (SYNC=0 BACK=1 ACTIVE=2 FRONT=3)
//     Phase_v_dbg  vertical phase FSM state
//
//   Handshake: Data_req is a level, not a valid/ready pair. Upstream samples
//   it on an En cycle and must present pixel data before the following En.
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int REZ_MAX_WIDTH = VGA_REZ_MAX_WIDTH,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BACK        = VGA_H_BACK,
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FRONT       = VGA_H_FRONT,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BACK        = VGA_V_BACK,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FRONT       = VGA_V_FRONT
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     En,
  output logic [REZ_MAX_WIDTH-1:0] Count_h,
  output logic [REZ_MAX_WIDTH-1:0] Count_v,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     Active,
  output logic                     Data_req,
  output logic                     Line_start,
  output logic                     Frame_start,
  output logic [1:0]               Phase_h_dbg,
  output logic [1:0]               Phase_v_dbg
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_LEFT  = H_SYNC + H_BACK;
  localparam int H_RIGHT = H_LEFT + H_ACTIVE;
  localparam int V_LEFT  = V_SYNC + V_BACK;
  localparam int V_RIGHT = V_LEFT + V_ACTIVE;

  localparam logic [REZ_MAX_WIDTH-1:0] H_LAST_C  = REZ_MAX_WIDTH'(H_TOTAL - 1);
  // Next pixel is visible when the current one is in [H_LEFT-1, H_RIGHT-1).
  localparam logic [REZ_MAX_WIDTH-1:0] H_PRE_C   = REZ_MAX_WIDTH'(H_LEFT - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_PREND_C = REZ_MAX_WIDTH'(H_RIGHT - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_LEFT_C  = REZ_MAX_WIDTH'(V_LEFT);
  localparam logic [REZ_MAX_WIDTH-1:0] V_RIGHT_C = REZ_MAX_WIDTH'(V_RIGHT);

  logic [REZ_MAX_WIDTH-1:0] h_cnt, h_cnt_d, v_cnt, v_cnt_d;
  logic [1:0]               h_ph, h_ph_d, v_ph, v_ph_d;
  logic                     v_step;

  assign v_step = En & (h_cnt == H_LAST_C);

  vga_axis_counter #(
    .WIDTH(REZ_MAX_WIDTH), .SYNC_LEN(H_SYNC), .LEFT(H_LEFT),
    .RIGHT(H_RIGHT), .TOTAL(H_TOTAL)
  ) u_h_axis (
    .clk_i(Clk), .rst_i(Rst), .step_i(En),
    .count_o(h_cnt), .count_d_o(h_cnt_d), .phase_o(h_ph), .phase_d_o(h_ph_d)
  );

  vga_axis_counter #(
    .WIDTH(REZ_MAX_WIDTH), .SYNC_LEN(V_SYNC), .LEFT(V_LEFT),
    .RIGHT(V_RIGHT), .TOTAL(V_TOTAL)
  ) u_v_axis (
    .clk_i(Clk), .rst_i(Rst), .step_i(v_step),
    .count_o(v_cnt), .count_d_o(v_cnt_d), .phase_o(v_ph), .phase_d_o(v_ph_d)
  );

  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic active_q, active_d, data_req_q, data_req_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  // With En low the next counts/phases equal the current ones, so the
  // level outputs hold naturally; only the pulses need the En qualifier.
  always_comb begin
    hsync_d       = (h_ph_d == PH_SYNC) ? SYNC_ACTIVE_LVL : !SYNC_ACTIVE_LVL;
    vsync_d       = (v_ph_d == PH_SYNC) ? SYNC_ACTIVE_LVL : !SYNC_ACTIVE_LVL;
    active_d      = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
    // Inside the pre-window the line cannot wrap, so the next line index is
    // unchanged; at H_TOTAL-1 the next pixel is 0, which is never visible.
    data_req_d    = (h_cnt_d >= H_PRE_C) && (h_cnt_d < H_PREND_C) &&
                    (v_cnt_d >= V_LEFT_C) && (v_cnt_d < V_RIGHT_C);
    line_start_d  = En && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hsync_q       <= !SYNC_ACTIVE_LVL;
      vsync_q       <= !SYNC_ACTIVE_LVL;
      active_q      <= 1'b0;
      data_req_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      data_req_q    <= data_req_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign Count_h     = h_cnt;
  assign Count_v     = v_cnt;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Active      = active_q;
  assign Data_req    = data_req_q;
  assign Line_start  = line_start_q;
  assign Frame_start = frame_start_q;
  assign Phase_h_dbg = h_ph;
  assign Phase_v_dbg = v_ph;

endmodule
